// File: rtl/gamepad_scanner.sv
// Serial game controller scanner: latches two pads, shifts out 16 bits each and
// publishes both results together once the whole scan is complete.
module gamepad_scanner #(
    parameter int unsigned LATCH_CYCLES = 300,
    parameter int unsigned HALF_PERIOD  = 150
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        p1_data,
    input  logic        p2_data,
    output logic        pad_latch,
    output logic        pad_clk,
    output logic [15:0] p1_buttons,
    output logic [15:0] p2_buttons,
    output logic        busy,
    output logic        scan_done
);

    localparam int unsigned MaxPhase = (LATCH_CYCLES > HALF_PERIOD) ? LATCH_CYCLES : HALF_PERIOD;
    localparam int unsigned CntW     = $clog2(MaxPhase);

    localparam logic [CntW-1:0] LatchLast = CntW'(LATCH_CYCLES - 1);
    localparam logic [CntW-1:0] HalfLast  = CntW'(HALF_PERIOD - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLatch,
        StClkLow,
        StClkHigh,
        StDone
    } state_e;

    state_e            r_state;
    state_e            w_state_next;
    logic [CntW-1:0]   r_cnt;
    logic [CntW-1:0]   w_cnt_next;
    logic [3:0]        r_bit;
    logic [3:0]        w_bit_next;
    logic              w_sample;
    logic [1:0]        r_p1_sync;
    logic [1:0]        r_p2_sync;
    logic [15:0]       r_p1_shadow;
    logic [15:0]       r_p2_shadow;
    logic              r_pad_latch;
    logic              r_pad_clk;
    logic              r_busy;
    logic              r_scan_done;
    logic [15:0]       r_p1_buttons;
    logic [15:0]       r_p2_buttons;

    // Two-flop synchronisers for the asynchronous pad data lines (idle high).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_p1_sync <= 2'b11;
            r_p2_sync <= 2'b11;
        end else begin
            r_p1_sync <= {r_p1_sync[0], p1_data};
            r_p2_sync <= {r_p2_sync[0], p2_data};
        end
    end

    // Next-state, phase counter and bit index; start is only honoured in idle.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_bit_next   = r_bit;
        w_sample     = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (start) begin
                    w_state_next = StLatch;
                    w_cnt_next   = '0;
                end
            end
            StLatch: begin
                if (r_cnt == LatchLast) begin
                    w_state_next = StClkLow;
                    w_cnt_next   = '0;
                    w_bit_next   = 4'd0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            StClkLow: begin
                if (r_cnt == HalfLast) begin
                    w_state_next = StClkHigh;
                    w_cnt_next   = '0;
                    w_sample     = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            StClkHigh: begin
                if (r_cnt == HalfLast) begin
                    w_cnt_next = '0;
                    if (r_bit == 4'd15) begin
                        w_state_next = StDone;
                    end else begin
                        w_state_next = StClkLow;
                        w_bit_next   = r_bit + 4'd1;
                    end
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            StDone: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // State, counters and state-decoded output flops (outputs track the state they are in).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_bit       <= 4'd0;
            r_pad_latch <= 1'b0;
            r_pad_clk   <= 1'b1;
            r_busy      <= 1'b0;
            r_scan_done <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_bit       <= w_bit_next;
            r_pad_latch <= (w_state_next == StLatch);
            r_pad_clk   <= (w_state_next != StClkLow);
            r_busy      <= (w_state_next == StLatch) || (w_state_next == StClkLow) ||
                           (w_state_next == StClkHigh);
            r_scan_done <= (w_state_next == StDone);
        end
    end

    // Shadow capture at the end of each low phase; data is active-low so invert.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_p1_shadow <= '0;
            r_p2_shadow <= '0;
        end else if (w_sample) begin
            r_p1_shadow[r_bit] <= ~r_p1_sync[1];
            r_p2_shadow[r_bit] <= ~r_p2_sync[1];
        end
    end

    // Publish both players at once from DONE so outputs never show a partial scan.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_p1_buttons <= '0;
            r_p2_buttons <= '0;
        end else if (r_state == StDone) begin
            r_p1_buttons <= r_p1_shadow;
            r_p2_buttons <= r_p2_shadow;
        end
    end

    assign pad_latch  = r_pad_latch;
    assign pad_clk    = r_pad_clk;
    assign busy       = r_busy;
    assign scan_done  = r_scan_done;
    assign p1_buttons = r_p1_buttons;
    assign p2_buttons = r_p2_buttons;

endmodule
